// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared types and constants for the data memory controller
package data_mem_ctrl_pkg;

    // SRAM half-word address width (18 bits addresses 256K half-words)
    localparam int SRAM_ADDR_W = 18;

    // Byte address of SRAM word 0 unless the instance overrides it
    localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

    // Wait counter width; holds SRAM_WAIT-1 for SRAM_WAIT up to 15
    localparam int WAIT_CNT_W = 4;

    // Access sequencer states: low half then high half, then one ready cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage bridge splitting 32-bit loads/stores into two 16-bit SRAM accesses
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          SRAM_WAIT = 2,
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            alu_res,
    input  logic [31:0]            val_rm,
    output logic                   ready,
    output logic [31:0]            read_data,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_wdata,
    input  logic [15:0]            sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    // Counter reload value so that each half stays SRAM_WAIT cycles
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(SRAM_WAIT - 1);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    state_t                  state;
    state_t                  next_state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [16:0]             word_idx_q;
    logic [31:0]             wdata_q;
    logic                    is_write_q;
    logic                    req;
    logic                    last_cycle;
    logic [31:0]             byte_off;
    logic                    unused_off_bits;

    assign req        = mem_r_en | mem_w_en;
    assign last_cycle = (wait_cnt == '0);

    // Offset from the SRAM window base wraps modulo 2^32; only word index bits are kept
    assign byte_off        = alu_res - MEM_BASE;
    assign unused_off_bits = ^{byte_off[31:19], byte_off[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Wait counter: reloaded on every state change, counts down to zero while the state holds
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (next_state != state) begin
            wait_cnt <= WAIT_LOAD;
        end else if (!last_cycle) begin
            wait_cnt <= wait_cnt - CNT_ONE;
        end
    end

    // Capture the request on IDLE->LO so the requester's inputs need not be sampled again
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx_q <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else if (state == ST_IDLE && req) begin
            word_idx_q <= byte_off[18:2];
            wdata_q    <= val_rm;
            is_write_q <= mem_w_en;
        end
    end

    // Load result: each half is sampled in the final cycle of its SRAM access
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (!is_write_q && last_cycle) begin
            if (state == ST_LO) begin
                read_data[15:0] <= sram_rdata;
            end else if (state == ST_HI) begin
                read_data[31:16] <= sram_rdata;
            end
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req)        next_state = ST_LO;
            ST_LO:   if (last_cycle) next_state = ST_HI;
            ST_HI:   if (last_cycle) next_state = ST_DONE;
            ST_DONE:                 next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    // Outputs: pipeline handshake and SRAM pin drive for the current half
    always_comb begin
        ready      = (state == ST_DONE) || (state == ST_IDLE && !req);
        sram_addr  = '0;
        sram_wdata = '0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        case (state)
            ST_LO: begin
                sram_addr = {word_idx_q, 1'b0};
                if (is_write_q) begin
                    sram_wdata = wdata_q[15:0];
                    sram_we_n  = !last_cycle;
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            ST_HI: begin
                sram_addr = {word_idx_q, 1'b1};
                if (is_write_q) begin
                    sram_wdata = wdata_q[31:16];
                    sram_we_n  = !last_cycle;
                end else begin
                    sram_oe_n  = 1'b0;
                end
            end
            default: begin
                sram_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'd1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0, w0, ready0, we0_n, oe0_n;
    logic [31:0] a0, d0, rd0;
    logic [17:0] sa0;
    logic [15:0] swd0, srd0;
    logic        r1, w1, ready1, we1_n, oe1_n;
    logic [31:0] a1, d1, rd1;
    logic [17:0] sa1;
    logic [15:0] swd1, srd1;

    data_mem_ctrl dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r0), .mem_w_en(w0), .alu_res(a0), .val_rm(d0),
        .ready(ready0), .read_data(rd0), .sram_addr(sa0), .sram_wdata(swd0),
        .sram_rdata(srd0), .sram_we_n(we0_n), .sram_oe_n(oe0_n)
    );

    data_mem_ctrl #(.SRAM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .mem_r_en(r1), .mem_w_en(w1), .alu_res(a1), .val_rm(d1),
        .ready(ready1), .read_data(rd1), .sram_addr(sa1), .sram_wdata(swd1),
        .sram_rdata(srd1), .sram_we_n(we1_n), .sram_oe_n(oe1_n)
    );

    // External SRAM chip for dut0; dut1 sees an address-derived pattern
    bit [15:0] sram0 [0:262143];
    always @(posedge clk) if (!we0_n) sram0[sa0] <= swd0;
    assign srd0 = oe0_n ? 16'hFFFF : sram0[sa0];
    assign srd1 = oe1_n ? 16'hFFFF : (sa1[15:0] ^ 16'h5A5A);

    typedef struct packed {
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Word-addressed reference memory and the last value a load returned
    logic [31:0] ref_mem [int];
    logic [31:0] last_load = 32'h0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request on dut0, starting at posedge+1 in IDLE; returns read_data seen in DONE
    task automatic transact(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
        int          cyc;
        int          oe_cnt;
        bit          done;
        wr_t         wl[$];
        logic [16:0] idx;
        logic [31:0] exp_rd;
        idx    = 17'((a - BASE) >> 2);
        cyc    = 0;
        oe_cnt = 0;
        done   = 1'b0;
        w0 = w; r0 = r; a0 = a; d0 = d;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!we0_n) wl.push_back({sa0, swd0});
            if (!oe0_n) oe_cnt++;
            if (ready0) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        rd = rd0;
        check("completed", 64'(done), 64'd1);
        check("latency", 64'(cyc), 64'd6);
        if (w) begin
            ref_mem[int'(idx)] = d;
            exp_rd = last_load;
        end else begin
            exp_rd = ref_mem.exists(int'(idx)) ? ref_mem[int'(idx)] : 32'h0;
            last_load = exp_rd;
        end
        check("read_data_model", 64'(rd0), 64'(exp_rd));
        check("we_strobes", 64'(wl.size()), w ? 64'd2 : 64'd0);
        check("oe_cycles", 64'(oe_cnt), w ? 64'd0 : 64'd4);
        if (w && wl.size() == 2) begin
            check("wr_lo", 64'({wl[0].addr, wl[0].data}), 64'({idx, 1'b0, d[15:0]}));
            check("wr_hi", 64'({wl[1].addr, wl[1].data}), 64'({idx, 1'b1, d[31:16]}));
        end
        @(posedge clk);
        #1;
        w0 = 1'b0; r0 = 1'b0;
    endtask

    vec_t        vecs[10];
    logic [31:0] rd;
    logic        rw, rr;
    logic [31:0] ra, rdat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1035, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 32'hCAFEF00D};
        vecs[7] = '{1'b0, 1'b1, 32'd1022, 32'h0,        32'h0BADC0DE};
        vecs[8] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEADBEEF};
        vecs[9] = '{1'b0, 1'b1, 32'd1100, 32'h0,        32'h00000000};

        rst = 1'b1;
        r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready0), 64'd1);
        check("rst_read_data", 64'(rd0), 64'd0);
        check("rst_we_n", 64'(we0_n), 64'd1);
        check("rst_oe_n", 64'(oe0_n), 64'd1);
        check("rst_addr", 64'(sa0), 64'd0);
        check("rst_wdata", 64'(swd0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            transact(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, rd);
            check($sformatf("vec%0d_read_data", i), 64'(rd), 64'(vecs[i].exp_rd));
        end

        // SRAM_WAIT=1 instance: load held high back-to-back, 4-cycle period
        r1 = 1'b1; a1 = BASE + 32'd8;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("w1_ready_c%0d", k), 64'(ready1), 64'(k % 4 == 3));
            check($sformatf("w1_oe_c%0d", k), 64'(oe1_n), 64'(!(k % 4 == 1 || k % 4 == 2)));
            check("w1_we_n", 64'(we1_n), 64'd1);
            check("w1_wdata", 64'(swd1), 64'd0);
            if (k % 4 == 3) check("w1_read_data", 64'(rd1), 64'h5A5F5A5E);
            @(posedge clk);
            #1;
        end
        r1 = 1'b0;

        // Randomized traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rr   = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            ra   = BASE + 32'($urandom_range(0, 31) << 2) + 32'($urandom_range(0, 3));
            rdat = $urandom;
            transact(rw, rr, ra, rdat, rd);
        end

        // Reset in the second HI cycle of a store
        w0 = 1'b1; a0 = 32'd2048; d0 = 32'hA5A55A5A;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("abort_in_hi_strobe", 64'({sa0[0], we0_n}), 64'({1'b1, 1'b0}));
        rst = 1'b1;
        w0  = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", 64'(dut0.state), 64'(ST_IDLE));
        check("abort_ready", 64'(ready0), 64'd1);
        check("abort_we_n", 64'(we0_n), 64'd1);
        check("abort_oe_n", 64'(oe0_n), 64'd1);
        check("abort_addr", 64'(sa0), 64'd0);
        check("abort_read_data", 64'(rd0), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
